sync_filter_bank: RTL and testbench



---
 rtl/sync_filter_bank_pkg.sv | 17 +
 rtl/sync_filter_chan.sv | 80 ++++++++
 rtl/sync_filter_bank.sv | 41 ++++
 tb/tb_sync_filter_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_filter_bank_pkg.sv
// Shared sizing helpers for the synchronizer / glitch-filter bank.
package sync_filter_bank_pkg;

  // Below this many synchronizer flops metastability settling time is marginal.
  localparam int unsigned MIN_SAFE_STAGES = 2;

  // Counter width that holds 0..filter without wrapping; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned filter);
    return (filter == 0) ? 1 : $clog2(filter + 1);
  endfunction

  // Physical chain length; keeps declarations legal even when STAGES is rejected.
  function automatic int unsigned chain_len(input int unsigned stages);
    return (stages < 1) ? 1 : stages;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: CDC flop chain, stable-count glitch filter, registered edge pulses.
module sync_filter_chan
  import sync_filter_bank_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILTER  = 0,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   SW      = chain_len(STAGES);
  localparam int unsigned   CW      = cnt_width(FILTER);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

  logic [SW-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          s;

  // Shift the raw input one stage deeper each edge; stage 0 is the only flop that sees d_i.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = d_i;
    for (int k = 1; k < int'(SW); k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SW-1];

  // Filter: q only adopts s after s has disagreed for FILTER+1 consecutive edges.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (s != q_q) begin
      if (cnt_q == CNT_MAX) begin
        q_d   = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Edge pulses are computed from the upcoming q so they line up with the new q_o value.
  always_comb begin
    rise_d = ~q_q & q_d;
    fall_d = q_q & ~q_d;
  end

  // State registers; reset restores the chain and q to RST_VAL so reset itself never pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SW{RST_VAL}};
      cnt_q  <= '0;
      q_q    <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer + glitch filter + edge detector for asynchronous inputs.
module sync_filter_bank
  import sync_filter_bank_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      STAGES  = 2,
  parameter int unsigned      FILTER  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Reject a chain with no flops; flag a single-flop chain as metastability-prone.
  if (STAGES == 0) begin : g_stages_err
    $error("sync_filter_bank: STAGES must be at least 1");
  end else if (STAGES < MIN_SAFE_STAGES) begin : g_stages_warn
    $warning("sync_filter_bank: STAGES=%0d, at least 2 recommended", STAGES);
  end

  // Channels are fully independent; each gets its own reset value bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    sync_filter_chan #(
      .STAGES  (STAGES),
      .FILTER  (FILTER),
      .RST_VAL (RST_VAL[i])
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (d_i[i]),
      .q_o    (q_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: a filtered instance and an unfiltered instance side by side.
module tb_sync_filter_bank;

  localparam int W  = 12;          // {q, rise, fall} for 4 channels
  localparam int SA = 2;
  localparam int FA = 3;
  localparam int SB = 3;
  localparam int FB = 0;
  localparam logic [3:0] RA = 4'b0010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic [3:0] d_a, q_a, rise_a, fall_a;
  logic [3:0] d_b, q_b, rise_b, fall_b;

  sync_filter_bank #(.WIDTH(4), .STAGES(SA), .FILTER(FA), .RST_VAL(RA)) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .d_i(d_a), .q_o(q_a), .rise_o(rise_a), .fall_o(fall_a)
  );

  sync_filter_bank #(.WIDTH(4), .STAGES(SB), .FILTER(FB), .RST_VAL(4'b0000)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .d_i(d_b), .q_o(q_b), .rise_o(rise_b), .fall_o(fall_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] mon_a, mon_b;
  logic [3:0]   cur_a, cur_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_a_q.size() != 0) begin
        mon_a = exp_a_q.pop_front();
        check($sformatf("a_q@%0d", cyc),    32'(q_a),    32'(mon_a[11:8]));
        check($sformatf("a_rise@%0d", cyc), 32'(rise_a), 32'(mon_a[7:4]));
        check($sformatf("a_fall@%0d", cyc), 32'(fall_a), 32'(mon_a[3:0]));
      end
      if (exp_b_q.size() != 0) begin
        mon_b = exp_b_q.pop_front();
        check($sformatf("b_q@%0d", cyc),    32'(q_b),    32'(mon_b[11:8]));
        check($sformatf("b_rise@%0d", cyc), 32'(rise_b), 32'(mon_b[7:4]));
        check($sformatf("b_fall@%0d", cyc), 32'(fall_b), 32'(mon_b[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of stimulus and push the outputs expected right after the next edge.
  task automatic step(input logic ra, input logic rb, input logic [3:0] da, input logic [3:0] db,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    @(negedge clk);
    rst_a_n = ra;
    rst_b_n = rb;
    d_a     = da;
    d_b     = db;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  // Pulse one channel of dut_a away from its settled value for len cycles.
  // Accepted pulses (len >= FA+1) move q at index SA+FA and return at index len+SA+FA.
  task automatic pulse_a(input int ch, input int len, input int span);
    logic [3:0] base, dv, qv, rv, fv;
    int t1, t2;
    bit acc;
    base = cur_a;
    t1   = SA + FA;
    t2   = len + SA + FA;
    acc  = (len >= FA + 1);
    for (int j = 0; j < span; j++) begin
      dv = base;
      if (j < len) dv[ch] = ~base[ch];
      qv = base;
      rv = '0;
      fv = '0;
      if (acc && j >= t1 && j < t2) qv[ch] = ~base[ch];
      if (acc && j == t1) begin
        if (base[ch]) fv[ch] = 1'b1; else rv[ch] = 1'b1;
      end
      if (acc && j == t2) begin
        if (base[ch]) rv[ch] = 1'b1; else fv[ch] = 1'b1;
      end
      step(1'b1, 1'b1, dv, cur_b, {qv, rv, fv}, {cur_b, 8'h00});
    end
  endtask

  // Square-wave the masked channels of dut_b; without filtering q is d delayed SB+FB edges.
  task automatic b_wave(input logic [3:0] mask, input int period, input int n);
    logic [3:0] base, prev, dv, qv, rv, fv;
    logic [3:0] dh[$];
    int lat;
    base = cur_b;
    prev = base;
    lat  = SB + FB;
    for (int j = 0; j < n + lat + 2; j++) begin
      dv = (j < n && ((j / period) % 2 == 0)) ? (base ^ mask) : base;
      dh.push_back(dv);
      qv   = (j >= lat) ? dh[j-lat] : base;
      rv   = ~prev & qv;
      fv   = prev & ~qv;
      prev = qv;
      step(1'b1, 1'b1, cur_a, dv, {cur_a, 8'h00}, {qv, rv, fv});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] qa, ra_v, fa_v, msk;
    int ch, len, per;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    d_a     = '0;
    d_b     = '0;
    repeat (3) @(negedge clk);

    check("rst_a_q",    32'(q_a),    32'(RA));
    check("rst_a_rise", 32'(rise_a), 32'(0));
    check("rst_a_fall", 32'(fall_a), 32'(0));
    check("rst_b_q",    32'(q_b),    32'(0));
    check("rst_b_edge", 32'({rise_b, fall_b}), 32'(0));

    // Release with d=0: channel 1 of dut_a leaves its reset value of 1 on edge SA+FA+1.
    for (int j = 0; j < 10; j++) begin
      qa   = (j >= SA + FA) ? 4'b0000 : RA;
      fa_v = (j == SA + FA) ? 4'b0010 : 4'b0000;
      step(1'b1, 1'b1, 4'b0000, 4'b0000, {qa, 4'b0000, fa_v}, 12'h000);
    end
    cur_a = 4'b0000;
    cur_b = 4'b0000;

    // Glitch rejection at exactly FILTER cycles, acceptance at FILTER+1.
    pulse_a(0, 3, 12);
    pulse_a(0, 4, 14);
    pulse_a(2, 1, 10);
    pulse_a(3, 6, 16);

    // Random pulses on dut_a.
    for (int r = 0; r < 6; r++) begin
      ch  = $urandom_range(0, 3);
      len = $urandom_range(1, 7);
      pulse_a(ch, len, len + SA + FA + 3);
    end

    // Unfiltered instance: multi-channel simultaneous change, then toggles every 5 cycles.
    b_wave(4'b1101, 8, 16);
    b_wave(4'b0100, 5, 20);
    for (int r = 0; r < 4; r++) begin
      msk = 4'($urandom_range(1, 15));
      per = $urandom_range(1, 6);
      b_wave(msk, per, 2 * per * $urandom_range(1, 2));
    end

    // Reset mid-count: channel 0 of dut_a reaches cnt==2 on the fourth edge.
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b1, 4'b0001, cur_b, {cur_a, 8'h00}, {cur_b, 8'h00});
    end
    @(posedge clk);
    #3;
    rst_a_n = 1'b0;
    #1;
    check("midrst_q",    32'(q_a),    32'(RA));
    check("midrst_rise", 32'(rise_a), 32'(0));
    check("midrst_fall", 32'(fall_a), 32'(0));
    repeat (2) @(negedge clk);
    check("midrst_hold_q", 32'(q_a), 32'(RA));

    // After release with d held, both channel 0 and channel 1 transition after the full latency.
    for (int j = 0; j < 10; j++) begin
      qa   = (j >= SA + FA) ? 4'b0001 : RA;
      ra_v = (j == SA + FA) ? 4'b0001 : 4'b0000;
      fa_v = (j == SA + FA) ? 4'b0010 : 4'b0000;
      step(1'b1, 1'b1, 4'b0001, cur_b, {qa, ra_v, fa_v}, {cur_b, 8'h00});
    end
    cur_a = 4'b0001;

    // Let the monitor consume the last entries, bounded.
    for (int k = 0; k < 5 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); k++) begin
      @(posedge clk);
      #2;
    end
    check("drain", 32'(exp_a_q.size() + exp_b_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
